im_loader: RTL and testbench
============================

# im_loader

Boot-time instruction loader: receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them sequentially into the instruction memory's write port starting at the text-segment base 0x3000. It is the writer counterpart of the read-only fetch path. It sits between a host byte source (UART receiver or testbench) and the instruction memory, and asserts `busy` to hold the CPU while loading.

## Interface
- `BASE_ADDR`, 32'h0000_3000: byte address of the first written word
- `DEPTH`, 4096: instruction memory capacity in words; larger loads are rejected
- `clk`  input  1  system clock, all state changes on rising edge
- `reset`  input  1  asynchronous, active-high reset
- `start`  input  1  one-cycle request to begin a load; ignored while `busy`
- `in_data`  input  8  stream byte
- `in_valid`  input  1  `in_data` is valid
- `in_ready`  output  1  loader accepts a byte this cycle
- `im_we`  output  1  one-cycle write strobe to instruction memory
- `im_addr`  output  32  byte address of the write, word aligned
- `im_wdata`  output  32  word to write
- `busy`  output  1  load in progress; CPU must be held
- `done`  output  1  load completed successfully; sticky until next `start` or `reset`
- `err`  output  1  load aborted; sticky until next `start` or `reset`

## Operation
- Byte accepted when `in_valid && in_ready`. `in_ready` is 1 only in HDR, DATA, CSUM.
- Words are big-endian: first accepted byte of a word is bits [31:24].
- Stream format: 4-byte header word N (word count), then N data words, then (with checksum) one checksum word.
- States: IDLE, HDR, DATA, CSUM (macro only), DONE, ERR.
- IDLE/DONE/ERR + `start` -> HDR; clears `done`, `err`, word index k, byte counter.
- HDR, 4th byte accepted: N > DEPTH -> ERR (no writes); N == 0 -> DONE (or CSUM with macro); else -> DATA.
- DATA, 4th byte of word k accepted: write issued with `im_addr` = BASE_ADDR + 4*k; k increments; after word N-1 -> DONE (or CSUM).
- CSUM, 4th byte accepted: checksum matches -> DONE, else ERR.
- `busy` = 1 in HDR, DATA, CSUM.
- `start` while `busy`: ignored, no effect on the load.
- Address arithmetic is 32-bit; k is 13 bits wide, so DEPTH words are addressable without wrap.

## Timing
- Reset values: `in_ready`=0, `im_we`=0, `im_addr`=BASE_ADDR, `im_wdata`=0, `busy`=0, `done`=0, `err`=0; state IDLE.
- `start` sampled at edge t -> `busy`=1 and `in_ready`=1 from cycle t+1.
- Completing byte accepted at edge t -> `im_we`=1 for exactly cycle t+1, with `im_addr`/`im_wdata` valid the same cycle; they hold until the next write.
- Sustained `in_valid` gives 1 word per 4 cycles; bubbles on `in_valid` only stall.
- Final completing byte at edge t -> `done` or `err` = 1 and `busy` = 0 from cycle t+1. The final `im_we` is also in cycle t+1.
- Reset mid-load: immediate return to IDLE with all outputs at their reset values. Words already written stay in memory.

## Configuration
- `IM_LOADER_CHECKSUM_EN` defined: a trailing checksum word is expected, equal to the XOR of all N data words; header excluded; N=0 gives expected value 0. On mismatch, `err`=1. Data words are already written and are not rolled back.
- Undefined: no CSUM state, no trailing word. `err` arises only from N > DEPTH.

## Structure
- Shared package `im_loader_pkg`: state encoding, `HDR_BYTES`=4, default `BASE_ADDR`, `DEPTH`.
- Sub-module `im_loader_asm`: byte-to-word shift register with a 2-bit byte counter. Outputs a one-cycle `word_valid` with the word. The FSM and address counter stay in `im_loader`.

## Test plan
- Reset, then `start`, then stream 00 00 00 02, 34 08 00 01, 00 00 00 0C with `in_valid` held high. Expect two `im_we` pulses: 0x3000 <= 0x34080001 and 0x3004 <= 0x0000000C. Expect `done`=1 one cycle after the last byte.
- Header 0x00001001 (4097 words). Expect `err`=1 the cycle after the 4th header byte, no `im_we`, and `in_ready`=0.
- Header 0, with the macro undefined. Expect `done` the cycle after the header and no writes.
- Random `in_valid` gaps, plus `start` pulsed mid-load. Expect identical writes to the gap-free run and the `start` ignored.
- Assert `reset` after 6 bytes accepted. Expect all outputs at their reset values on the next edge. A following `start` reloads from 0x3000.
- With `IM_LOADER_CHECKSUM_EN`: words 0x11111111 and 0x22222222 with checksum 0x33333333 -> `done`. The same load with checksum 0x33333332 -> `err`, after both writes have occurred.

Source files
------------

// File: rtl/im_loader_pkg.sv
// Shared definitions for the boot-time instruction loader: FSM state encoding,
// header length and default memory placement.
package im_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int          HDR_BYTES     = 4;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_3000;
  localparam int          DEF_DEPTH     = 4096;

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The slave modport is the loader; the master modport is the host/memory side.
interface im_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;

  modport master (output in_data, in_valid,
                  input  in_ready, im_we, im_addr, im_wdata);
  modport slave  (input  in_data, in_valid,
                  output in_ready, im_we, im_addr, im_wdata);
endinterface

// File: rtl/im_loader_asm.sv
// Big-endian byte-to-word assembler. word_valid is combinational so the loader
// can register the write on the same edge that accepts the completing byte.
module im_loader_asm
  import im_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam logic [1:0] LAST_BYTE = 2'(HDR_BYTES - 1);

  logic [1:0]  cnt_reg;
  logic [23:0] shift_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg   <= '0;
      shift_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (byte_en) begin
      cnt_reg   <= cnt_reg + 2'd1;
      shift_reg <= {shift_reg[15:0], byte_in};
    end
  end

  assign word_valid = byte_en && (cnt_reg == LAST_BYTE);
  assign word       = {shift_reg, byte_in};

endmodule

// File: rtl/im_loader.sv
// Boot loader: header word N, then N data words written from BASE_ADDR upward.
// Define IM_LOADER_CHECKSUM_EN to require a trailing XOR checksum word.
module im_loader
  import im_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          DEPTH     = DEF_DEPTH
)(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  im_loader_if.slave   bus,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t      state_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        err_reg;
  logic        we_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [12:0] k_reg;
  logic [12:0] n_reg;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [31:0] csum_reg;
`endif

  logic        accept;
  logic        launch;
  logic        word_valid;
  logic [31:0] word;

  assign accept = bus.in_valid && busy_reg;
  assign launch = start && !busy_reg;

  im_loader_asm u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (launch),
    .byte_en    (accept),
    .byte_in    (bus.in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= BASE_ADDR;
      wdata_reg <= '0;
      k_reg     <= '0;
      n_reg     <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
      csum_reg  <= '0;
`endif
    end else begin
      we_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state_reg <= ST_HDR;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            k_reg     <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
            csum_reg  <= '0;
`endif
          end
        end
        ST_HDR: begin
          if (word_valid) begin
            n_reg <= word[12:0];
            if (word > DEPTH_W) begin
              state_reg <= ST_ERR;
              busy_reg  <= 1'b0;
              err_reg   <= 1'b1;
            end else if (word == 32'd0) begin
`ifdef IM_LOADER_CHECKSUM_EN
              state_reg <= ST_CSUM;
`else
              state_reg <= ST_DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
`endif
            end else begin
              state_reg <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (word_valid) begin
            we_reg    <= 1'b1;
            addr_reg  <= BASE_ADDR + {17'd0, k_reg, 2'b00};
            wdata_reg <= word;
            k_reg     <= k_reg + 13'd1;
`ifdef IM_LOADER_CHECKSUM_EN
            csum_reg  <= csum_reg ^ word;
`endif
            // k_reg still holds the index of the word being written
            if (k_reg == n_reg - 13'd1) begin
`ifdef IM_LOADER_CHECKSUM_EN
              state_reg <= ST_CSUM;
`else
              state_reg <= ST_DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
`endif
            end
          end
        end
`ifdef IM_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (word_valid) begin
            busy_reg <= 1'b0;
            if (word == csum_reg) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_ERR;
              err_reg   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_reg;
  assign done         = done_reg;
  assign err          = err_reg;
  assign bus.in_ready = busy_reg;
  assign bus.im_we    = we_reg;
  assign bus.im_addr  = addr_reg;
  assign bus.im_wdata = wdata_reg;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader; expected writes are queued as words are
// sent and popped by a monitor on each im_we pulse.
module tb_im_loader;
  import im_loader_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_3000;
`ifdef IM_LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic busy, done, err;

  im_loader_if bus();

  im_loader dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int writes = 0;
  bit timed_out = 1'b0;
  logic [63:0] exp_q[$];
  logic [31:0] words_q[$];

  always @(negedge clk) begin
    logic [63:0] e;
    if (bus.im_we === 1'b1) begin
      writes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got addr=%h data=%h expected none", bus.im_addr, bus.im_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({bus.im_addr, bus.im_wdata} !== e) begin
          errors++;
          $display("FAIL write got addr=%h data=%h expected addr=%h data=%h",
                   bus.im_addr, bus.im_wdata, e[63:32], e[31:0]);
        end else begin
          $display("write addr=%h data=%h ok", bus.im_addr, bus.im_wdata);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (timed_out) return;
    if (gaps) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      timed_out = 1'b1;
      checks++;
      errors++;
      $display("FAIL ready_timeout got in_ready=%b expected 1 within 50 cycles", bus.in_ready);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], gaps);
  endtask

  task automatic pulse_start();
    timed_out = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_stream(input bit gaps, input bit mid_start);
    logic [31:0] x;
    x = '0;
    send_word(32'(words_q.size()), gaps);
    for (int i = 0; i < words_q.size(); i++) begin
      exp_q.push_back({BASE + 32'(4 * i), words_q[i]});
      x = x ^ words_q[i];
      send_word(words_q[i], gaps);
      if (mid_start && i == 0) begin
        bus.in_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({busy, bus.in_ready, done} !== 3'b110) begin
          errors++;
          $display("FAIL mid_start got busy/ready/done=%b expected 110", {busy, bus.in_ready, done});
        end
      end
    end
    if (CSUM_ON) send_word(x, gaps);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.im_we, busy, done, err, bus.im_addr, bus.im_wdata} !== {5'b0, BASE, 32'h0}) begin
      errors++;
      $display("FAIL reset got rdy/we/busy/done/err=%b addr=%h wdata=%h expected 00000 %h 0",
               {bus.in_ready, bus.im_we, busy, done, err}, bus.im_addr, bus.im_wdata, BASE);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    pulse_start();
    checks++;
    if ({busy, bus.in_ready} !== 2'b11) begin
      errors++;
      $display("FAIL start_latency got busy/ready=%b expected 11", {busy, bus.in_ready});
    end
    words_q = '{32'h3408_0001, 32'h0000_000C};
    send_stream(1'b0, 1'b0);
    checks++;
    if ({bus.im_we, busy, bus.in_ready, done, err} !== {~CSUM_ON, 4'b0010}) begin
      errors++;
      $display("FAIL basic_end got we/busy/rdy/done/err=%b expected %b",
               {bus.im_we, busy, bus.in_ready, done, err}, {~CSUM_ON, 4'b0010});
    end
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0 || bus.im_addr !== 32'h3004 || bus.im_wdata !== 32'hC) begin
      errors++;
      $display("FAIL basic_hold got pending=%0d addr=%h data=%h expected 0 3004 0000000c",
               exp_q.size(), bus.im_addr, bus.im_wdata);
    end
  endtask

  task automatic test_oversize();
    int w0;
    w0 = writes;
    pulse_start();
    send_word(32'h0000_1001, 1'b0);
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.im_we, busy, bus.in_ready, done, err} !== 5'b00001) begin
      errors++;
      $display("FAIL oversize got we/busy/rdy/done/err=%b expected 00001",
               {bus.im_we, busy, bus.in_ready, done, err});
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (writes != w0) begin
      errors++;
      $display("FAIL oversize_writes got %0d expected 0", writes - w0);
    end
  endtask

  task automatic test_zero();
    int w0;
    w0 = writes;
    pulse_start();
    words_q = {};
    send_stream(1'b0, 1'b0);
    checks++;
    if ({bus.im_we, busy, bus.in_ready, done, err} !== 5'b00010) begin
      errors++;
      $display("FAIL zero_hdr got we/busy/rdy/done/err=%b expected 00010",
               {bus.im_we, busy, bus.in_ready, done, err});
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (writes != w0) begin
      errors++;
      $display("FAIL zero_writes got %0d expected 0", writes - w0);
    end
  endtask

  task automatic test_gaps_midstart();
    pulse_start();
    words_q = '{32'h3408_0001, 32'h0000_000C, 32'hDEAD_BEEF, 32'h0123_4567};
    send_stream(1'b1, 1'b1);
    @(negedge clk); #1;
    checks++;
    if ({busy, done, err} !== 3'b010 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL gaps_end got busy/done/err=%b pending=%0d expected 010 0",
               {busy, done, err}, exp_q.size());
    end
  endtask

  task automatic test_reset_midload();
    pulse_start();
    send_word(32'h0000_0002, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h08, 1'b0);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus.in_ready, bus.im_we, busy, done, err, bus.im_addr, bus.im_wdata} !== {5'b0, BASE, 32'h0}) begin
      errors++;
      $display("FAIL midload_reset got rdy/we/busy/done/err=%b addr=%h wdata=%h expected 00000 %h 0",
               {bus.in_ready, bus.im_we, busy, done, err}, bus.im_addr, bus.im_wdata, BASE);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    pulse_start();
    words_q = '{32'hCAFE_F00D, 32'h0000_0001};
    send_stream(1'b0, 1'b0);
    @(negedge clk); #1;
    checks++;
    if ({busy, done, err} !== 3'b010 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reload got busy/done/err=%b pending=%0d expected 010 0",
               {busy, done, err}, exp_q.size());
    end
  endtask

  task automatic test_full_depth();
    pulse_start();
    words_q = {};
    for (int i = 0; i < DEF_DEPTH; i++) words_q.push_back($urandom);
    send_stream(1'b0, 1'b0);
    @(negedge clk); #1;
    checks++;
    if ({busy, done, err} !== 3'b010 || exp_q.size() != 0 || bus.im_addr !== 32'h0000_6FFC) begin
      errors++;
      $display("FAIL full_depth got busy/done/err=%b pending=%0d last_addr=%h expected 010 0 00006ffc",
               {busy, done, err}, exp_q.size(), bus.im_addr);
    end
  endtask

`ifdef IM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [31:0] sums[2];
    int w0;
    sums[0] = 32'h3333_3333;
    sums[1] = 32'h3333_3332;
    for (int t = 0; t < 2; t++) begin
      w0 = writes;
      pulse_start();
      send_word(32'h0000_0002, 1'b0);
      exp_q.push_back({BASE, 32'h1111_1111});
      send_word(32'h1111_1111, 1'b0);
      exp_q.push_back({BASE + 32'd4, 32'h2222_2222});
      send_word(32'h2222_2222, 1'b0);
      send_word(sums[t], 1'b0);
      bus.in_valid = 1'b0;
      checks++;
      if ({busy, done, err} !== {1'b0, t == 0, t == 1} || writes - w0 != 2) begin
        errors++;
        $display("FAIL checksum_%0d got busy/done/err=%b writes=%0d expected %b 2",
                 t, {busy, done, err}, writes - w0, {1'b0, t == 0, t == 1});
      end
    end
  endtask
`endif

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_oversize();
    test_zero();
    test_gaps_midstart();
    test_reset_midload();
    test_full_depth();
`ifdef IM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_writes got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
